rvlab_tlul_host_arb: RTL and testbench

RVLAB_TLUL_HOST_ARB -- requirements
Module: rvlab_tlul_host_arb

---
 rtl/rvlab_tlul_host_arb.sv | 179 +++++++++++++++++
 tb/tb_rvlab_tlul_host_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvlab_tlul_host_arb.sv
// Two-host TL-UL arbiter: merges instruction/data hosts onto one device with
// zero-latency grant. Define RVLAB_TLUL_ARB_RR_EN for round-robin, else data host wins.
package rvlab_tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AUW = 16;
    localparam int TL_DUW = 16;

    localparam logic [2:0] TL_PUT_FULL = 3'h0;
    localparam logic [2:0] TL_GET      = 3'h4;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic [TL_AUW-1:0] a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } arb_state_e;
endpackage

module rvlab_tlul_host_arb
    import rvlab_tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_ih_i,
    output tl_d2h_t tl_ih_o,
    input  tl_h2d_t tl_dh_i,
    output tl_d2h_t tl_dh_o,
    output tl_h2d_t tl_dev_o,
    input  tl_d2h_t tl_dev_i
);
    localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
`ifdef RVLAB_TLUL_ARB_RR_EN
    logic            ptr_q, ptr_d;
`endif

    tl_h2d_t    host_req [2];
    logic       d_sel;
    logic       dev_d_ready;
    logic [1:0] d_hs;
    logic [1:0] elig;
    logic       gnt_valid;
    logic       gnt_idx;
    logic       a_hs;

    assign host_req[0] = tl_ih_i;
    assign host_req[1] = tl_dh_i;

    assign d_sel       = tl_dev_i.d_source[0];
    assign dev_d_ready = d_sel ? tl_dh_i.d_ready : tl_ih_i.d_ready;

    // A response retiring in this cycle frees a slot immediately, so a host at
    // its limit can be granted in the same cycle its d handshake completes.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        d_hs        = '0;
        d_hs[d_sel] = tl_dev_i.d_valid && dev_d_ready;
        for (int h = 0; h < 2; h++) begin
            elig[h] = host_req[h].a_valid && ((cnt_q[h] < MaxCnt) || d_hs[h]);
        end

        gnt_valid = 1'b0;
        gnt_idx   = 1'b1;
        unique case (state_q)
            HOLD0: begin gnt_valid = 1'b1; gnt_idx = 1'b0; end
            HOLD1: begin gnt_valid = 1'b1; gnt_idx = 1'b1; end
            default: begin
                if (elig == 2'b11) begin
                    gnt_valid = 1'b1;
`ifdef RVLAB_TLUL_ARB_RR_EN
                    gnt_idx   = ptr_q;
`else
                    gnt_idx   = 1'b1;
`endif
                end else if (elig[1]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 1'b1;
                end else if (elig[0]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = 1'b0;
                end
            end
        endcase
        if (!rst_ni) gnt_valid = 1'b0;
    end

    always_comb begin
        tl_dev_o          = host_req[gnt_idx];
        tl_dev_o.a_valid  = gnt_valid && host_req[gnt_idx].a_valid;
        tl_dev_o.a_source = {host_req[gnt_idx].a_source[TL_AIW-2:0], gnt_idx};
        tl_dev_o.d_ready  = dev_d_ready;
        a_hs              = tl_dev_o.a_valid && tl_dev_i.a_ready;

        tl_ih_o          = tl_dev_i;
        tl_ih_o.d_source = tl_dev_i.d_source >> 1;
        tl_ih_o.d_valid  = rst_ni && tl_dev_i.d_valid && !d_sel;
        tl_ih_o.a_ready  = tl_dev_i.a_ready && gnt_valid && !gnt_idx;

        tl_dh_o          = tl_dev_i;
        tl_dh_o.d_source = tl_dev_i.d_source >> 1;
        tl_dh_o.d_valid  = rst_ni && tl_dev_i.d_valid && d_sel;
        tl_dh_o.a_ready  = tl_dev_i.a_ready && gnt_valid && gnt_idx;
    end

    always_comb begin
        state_d = IDLE;
        if (tl_dev_o.a_valid && !tl_dev_i.a_ready) begin
            state_d = gnt_idx ? HOLD1 : HOLD0;
        end

        // Counters saturate at both ends; simultaneous a and d handshakes cancel.
        for (int h = 0; h < 2; h++) begin
            cnt_d[h] = cnt_q[h];
            if (a_hs && (gnt_idx == h[0]) && !d_hs[h] && (cnt_q[h] != MaxCnt)) begin
                cnt_d[h] = cnt_q[h] + CntW'(1);
            end else if (d_hs[h] && !(a_hs && (gnt_idx == h[0])) && (cnt_q[h] != '0)) begin
                cnt_d[h] = cnt_q[h] - CntW'(1);
            end
        end

`ifdef RVLAB_TLUL_ARB_RR_EN
        ptr_d = ptr_q;
        if (a_hs) ptr_d = ~gnt_idx;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            for (int h = 0; h < 2; h++) cnt_q[h] <= '0;
`ifdef RVLAB_TLUL_ARB_RR_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            for (int h = 0; h < 2; h++) cnt_q[h] <= cnt_d[h];
`ifdef RVLAB_TLUL_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_rvlab_tlul_host_arb.sv
// Directed bench for rvlab_tlul_host_arb: reset, routing, contention, stall,
// outstanding limit, simultaneous handshakes and mid-transfer reset.
module tb_rvlab_tlul_host_arb;
    import rvlab_tlul_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    tl_h2d_t ih_i, dh_i, dev_o;
    tl_d2h_t ih_o, dh_o, dev_i;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rvlab_tlul_host_arb #(.MaxOutstanding(2)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .tl_ih_i (ih_i),
        .tl_ih_o (ih_o),
        .tl_dh_i (dh_i),
        .tl_dh_o (dh_o),
        .tl_dev_o(dev_o),
        .tl_dev_i(dev_i)
    );

    task automatic idle_inputs();
        ih_i  = '0;
        dh_i  = '0;
        dev_i = '0;
    endtask

    // Leaves the bench at a falling edge with reset released and inputs idle.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        ih_i.a_valid  = 1'b1;
        ih_i.a_opcode = TL_GET;
        ih_i.d_ready  = 1'b1;
        dh_i.d_ready  = 1'b1;
        dev_i.a_ready = 1'b1;
        dev_i.d_valid = 1'b1;
        dev_i.d_source = 8'h01;
        #1;
        compared++;
        if (dev_o.a_valid !== 1'b0) begin mismatched++; $display("FAIL rst_dev_a_valid: got %b want 0", dev_o.a_valid); end
        compared++;
        if (ih_o.a_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ih_a_ready: got %b want 0", ih_o.a_ready); end
        compared++;
        if (dh_o.d_valid !== 1'b0 || ih_o.d_valid !== 1'b0) begin
            mismatched++; $display("FAIL rst_d_valid: got ih=%b dh=%b want 0/0", ih_o.d_valid, dh_o.d_valid);
        end
        @(negedge clk);
        #1;
        compared++;
        if (dut.state_q !== IDLE || dut.cnt_q[0] !== 2'd0 || dut.cnt_q[1] !== 2'd0) begin
            mismatched++; $display("FAIL rst_state: got st=%0d c0=%0d c1=%0d want 0/0/0", dut.state_q, dut.cnt_q[0], dut.cnt_q[1]);
        end
`ifdef RVLAB_TLUL_ARB_RR_EN
        compared++;
        if (dut.ptr_q !== 1'b1) begin mismatched++; $display("FAIL rst_ptr: got %b want 1", dut.ptr_q); end
`endif
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_host();
        apply_reset();
        dh_i.a_valid   = 1'b1;
        dh_i.a_opcode  = TL_GET;
        dh_i.a_size    = 2'd2;
        dh_i.a_mask    = 4'hF;
        dh_i.a_address = 32'h0000_0100;
        dh_i.a_source  = 8'h05;
        dh_i.a_user    = 16'hBEEF;
        dev_i.a_ready  = 1'b1;
        #1;
        compared++;
        if (dev_o.a_valid !== 1'b1 || dev_o.a_address !== 32'h100 || dev_o.a_user !== 16'hBEEF) begin
            mismatched++; $display("FAIL single_req: got v=%b addr=%h user=%h want 1/100/beef", dev_o.a_valid, dev_o.a_address, dev_o.a_user);
        end
        compared++;
        if (dev_o.a_source !== 8'h0B) begin mismatched++; $display("FAIL single_src: got %h want 0b", dev_o.a_source); end
        compared++;
        if (dh_o.a_ready !== 1'b1 || ih_o.a_ready !== 1'b0) begin
            mismatched++; $display("FAIL single_a_ready: got ih=%b dh=%b want 0/1", ih_o.a_ready, dh_o.a_ready);
        end
        @(negedge clk);
        dh_i.a_valid   = 1'b0;
        dh_i.d_ready   = 1'b1;
        ih_i.d_ready   = 1'b0;
        dev_i.d_valid  = 1'b1;
        dev_i.d_opcode = 3'h1;
        dev_i.d_source = 8'h0B;
        dev_i.d_data   = 32'hCAFE_F00D;
        #1;
        compared++;
        if (dut.cnt_q[1] !== 2'd1) begin mismatched++; $display("FAIL single_cnt_inc: got %0d want 1", dut.cnt_q[1]); end
        compared++;
        if (dh_o.d_valid !== 1'b1 || ih_o.d_valid !== 1'b0) begin
            mismatched++; $display("FAIL single_d_route: got ih=%b dh=%b want 0/1", ih_o.d_valid, dh_o.d_valid);
        end
        compared++;
        if (dh_o.d_source !== 8'h05 || dh_o.d_data !== 32'hCAFE_F00D || dev_o.d_ready !== 1'b1) begin
            mismatched++; $display("FAIL single_d_fields: got src=%h data=%h rdy=%b want 05/cafef00d/1", dh_o.d_source, dh_o.d_data, dev_o.d_ready);
        end
        @(negedge clk);
        dev_i.d_valid = 1'b0;
        #1;
        compared++;
        if (dut.cnt_q[1] !== 2'd0) begin mismatched++; $display("FAIL single_cnt_dec: got %0d want 0", dut.cnt_q[1]); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_g;
`ifdef RVLAB_TLUL_ARB_RR_EN
        exp_g = 4'b0101;
`else
        exp_g = 4'b1111;
`endif
        apply_reset();
        ih_i.a_valid   = 1'b1;
        ih_i.a_opcode  = TL_GET;
        ih_i.a_address = 32'h1000;
        ih_i.a_source  = 8'h01;
        dh_i.a_valid   = 1'b1;
        dh_i.a_opcode  = TL_GET;
        dh_i.a_address = 32'h2000;
        dh_i.a_source  = 8'h02;
        dh_i.d_ready   = 1'b1;
        dev_i.a_ready  = 1'b1;
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'h03;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (dev_o.a_valid !== 1'b1 || dev_o.a_source[0] !== exp_g[i]) begin
                mismatched++; $display("FAIL contention_grant[%0d]: got v=%b g=%b want 1/%b", i, dev_o.a_valid, dev_o.a_source[0], exp_g[i]);
            end
            compared++;
            if (dev_o.a_address !== (exp_g[i] ? 32'h2000 : 32'h1000)) begin
                mismatched++; $display("FAIL contention_addr[%0d]: got %h", i, dev_o.a_address);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        ih_i.a_valid   = 1'b1;
        ih_i.a_opcode  = TL_PUT_FULL;
        ih_i.a_address = 32'h300;
        ih_i.a_data    = 32'h1122_3344;
        ih_i.a_mask    = 4'hF;
        dev_i.a_ready  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                dh_i.a_valid   = 1'b1;
                dh_i.a_opcode  = TL_GET;
                dh_i.a_address = 32'h500;
            end
            if (c == 3) dev_i.a_ready = 1'b1;
            #1;
            compared++;
            if (dev_o.a_valid !== 1'b1 || dev_o.a_source[0] !== 1'b0 || dev_o.a_address !== 32'h300
                || dev_o.a_data !== 32'h1122_3344 || dev_o.a_opcode !== TL_PUT_FULL) begin
                mismatched++; $display("FAIL stall_hold[%0d]: got v=%b g=%b addr=%h data=%h", c, dev_o.a_valid, dev_o.a_source[0], dev_o.a_address, dev_o.a_data);
            end
            compared++;
            if (ih_o.a_ready !== (c == 3) || dh_o.a_ready !== 1'b0) begin
                mismatched++; $display("FAIL stall_ready[%0d]: got ih=%b dh=%b", c, ih_o.a_ready, dh_o.a_ready);
            end
            if (c == 1 || c == 2) begin
                compared++;
                if (dut.state_q !== HOLD0) begin mismatched++; $display("FAIL stall_state[%0d]: got %0d want HOLD0", c, dut.state_q); end
            end
            @(negedge clk);
        end
        ih_i.a_valid = 1'b0;
        #1;
        compared++;
        if (dut.state_q !== IDLE || dev_o.a_source[0] !== 1'b1 || dev_o.a_address !== 32'h500) begin
            mismatched++; $display("FAIL stall_release: got st=%0d g=%b addr=%h want IDLE/1/500", dut.state_q, dev_o.a_source[0], dev_o.a_address);
        end
        idle_inputs();
    endtask

    task automatic test_outstanding();
        apply_reset();
        ih_i.a_valid  = 1'b1;
        ih_i.a_opcode = TL_GET;
        dev_i.a_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            ih_i.a_address = (c < 2) ? 32'h400 + 32'(4 * c) : 32'h408;
            if (c == 4) begin
                ih_i.d_ready   = 1'b1;
                dev_i.d_valid  = 1'b1;
                dev_i.d_source = 8'h00;
            end
            #1;
            compared++;
            if (dev_o.a_valid !== (c < 2 || c == 4) || ih_o.a_ready !== (c < 2 || c == 4)) begin
                mismatched++; $display("FAIL limit_grant[%0d]: got v=%b rdy=%b", c, dev_o.a_valid, ih_o.a_ready);
            end
            if (c == 4) begin
                compared++;
                if (dev_o.a_address !== 32'h408 || ih_o.d_valid !== 1'b1 || dev_o.d_ready !== 1'b1) begin
                    mismatched++; $display("FAIL limit_release: got addr=%h dv=%b dr=%b want 408/1/1", dev_o.a_address, ih_o.d_valid, dev_o.d_ready);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        compared++;
        if (dut.cnt_q[0] !== 2'd2) begin mismatched++; $display("FAIL limit_cnt: got %0d want 2", dut.cnt_q[0]); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        dh_i.a_valid  = 1'b1;
        dh_i.a_opcode = TL_GET;
        dh_i.a_source = 8'h02;
        dev_i.a_ready = 1'b1;
        @(negedge clk);
        dh_i.d_ready   = 1'b1;
        dev_i.d_valid  = 1'b1;
        dev_i.d_source = 8'h05;
        #1;
        compared++;
        if (dut.cnt_q[1] !== 2'd1 || dev_o.a_valid !== 1'b1 || dh_o.d_valid !== 1'b1) begin
            mismatched++; $display("FAIL simul_pre: got c1=%0d av=%b dv=%b want 1/1/1", dut.cnt_q[1], dev_o.a_valid, dh_o.d_valid);
        end
        compared++;
        if (dh_o.d_source !== 8'h02) begin mismatched++; $display("FAIL simul_dsrc: got %h want 02", dh_o.d_source); end
        @(negedge clk);
        idle_inputs();
        #1;
        compared++;
        if (dut.cnt_q[1] !== 2'd1) begin mismatched++; $display("FAIL simul_cnt: got %0d want 1", dut.cnt_q[1]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ih_i.a_valid  = 1'b1;
        ih_i.a_opcode = TL_GET;
        dev_i.a_ready = 1'b1;
        @(negedge clk);
        ih_i.a_valid   = 1'b0;
        dh_i.a_valid   = 1'b1;
        dh_i.a_opcode  = TL_GET;
        dh_i.a_address = 32'h700;
        dev_i.a_ready  = 1'b0;
        @(negedge clk);
        #1;
        compared++;
        if (dut.state_q !== HOLD1 || dut.cnt_q[0] !== 2'd1) begin
            mismatched++; $display("FAIL midrst_pre: got st=%0d c0=%0d want HOLD1/1", dut.state_q, dut.cnt_q[0]);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (dev_o.a_valid !== 1'b0 || dh_o.a_ready !== 1'b0) begin
            mismatched++; $display("FAIL midrst_comb: got av=%b rdy=%b want 0/0", dev_o.a_valid, dh_o.a_ready);
        end
        @(negedge clk);
        #1;
        compared++;
        if (dut.state_q !== IDLE || dut.cnt_q[0] !== 2'd0 || dut.cnt_q[1] !== 2'd0 || dev_o.a_valid !== 1'b0) begin
            mismatched++; $display("FAIL midrst_post: got st=%0d c0=%0d c1=%0d av=%b want 0/0/0/0", dut.state_q, dut.cnt_q[0], dut.cnt_q[1], dev_o.a_valid);
        end
        rst_n = 1'b1;
        dev_i.a_ready = 1'b1;
        #1;
        compared++;
        if (dev_o.a_valid !== 1'b1 || dev_o.a_source[0] !== 1'b1 || dev_o.a_address !== 32'h700) begin
            mismatched++; $display("FAIL midrst_represent: got v=%b g=%b addr=%h want 1/1/700", dev_o.a_valid, dev_o.a_source[0], dev_o.a_address);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_host();
        test_contention();
        test_stall();
        test_outstanding();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
